// File: rtl/xspi_pkg.sv
// xspi_pkg: shared definitions for the oversampling xSPI slave PHY.
//   - bus-width (mode) encodings carried on txnmode_i
//   - PHY state enumeration
//   - helpers mapping a mode to bits-per-beat and to the lanes it drives
package xspi_pkg;

  localparam logic [1:0] XSPI_MODE_SINGLE = 2'b00;
  localparam logic [1:0] XSPI_MODE_DUAL   = 2'b01;
  localparam logic [1:0] XSPI_MODE_QUAD   = 2'b10;

  typedef enum logic [1:0] {
    DESEL = 2'b00,
    SEL   = 2'b01,
    RX    = 2'b10,
    TX    = 2'b11
  } xspi_state_t;

  // Bits transferred per SCK beat; 0 flags the reserved encoding.
  function automatic logic [2:0] xspi_bpb(input logic [1:0] mode);
    case (mode)
      XSPI_MODE_SINGLE: xspi_bpb = 3'd1;
      XSPI_MODE_DUAL:   xspi_bpb = 3'd2;
      XSPI_MODE_QUAD:   xspi_bpb = 3'd4;
      default:          xspi_bpb = 3'd0;
    endcase
  endfunction

  // Lanes driven while transmitting. Single-bit transmit uses sio[1]
  // (classic MISO position), so its mask differs from its receive lane.
  function automatic logic [3:0] xspi_tx_lanes(input logic [1:0] mode);
    case (mode)
      XSPI_MODE_SINGLE: xspi_tx_lanes = 4'b0010;
      XSPI_MODE_DUAL:   xspi_tx_lanes = 4'b0011;
      XSPI_MODE_QUAD:   xspi_tx_lanes = 4'b1111;
      default:          xspi_tx_lanes = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/xspi_sync.sv
// xspi_sync: brings the raw SCK/SCE/SIO pins into the clk domain.
//   clk, rst_n             system clock, async active-low reset
//   sck, sce, sio[3:0]     raw pins
//   sck_rise, sck_fall     one-clk pulses on synchronised SCK edges
//   sce_level              synchronised chip-enable level
//   sce_rise, sce_fall     one-clk pulses on synchronised SCE edges
//   sio_sync[3:0]          synchronised data lanes
// SIO uses the same depth as SCK, so the lane value seen with a rise
// pulse is the one present at the pins when SCK rose.
module xspi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       sce,
  input  logic [3:0] sio,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       sce_level,
  output logic       sce_rise,
  output logic       sce_fall,
  output logic [3:0] sio_sync
);

  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] sce_pipe;
  logic [3:0]             sio_pipe [SYNC_STAGES];
  logic                   sck_dly;
  logic                   sce_dly;
  logic                   sck_s;
  logic                   sce_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_pipe <= '0;
      sce_pipe <= '0;
      sck_dly  <= 1'b0;
      sce_dly  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sio_pipe[i] <= '0;
    end else begin
      sck_pipe <= {sck_pipe[SYNC_STAGES-2:0], sck};
      sce_pipe <= {sce_pipe[SYNC_STAGES-2:0], sce};
      sck_dly  <= sck_s;
      sce_dly  <= sce_s;
      sio_pipe[0] <= sio;
      for (int i = 1; i < SYNC_STAGES; i++) sio_pipe[i] <= sio_pipe[i-1];
    end
  end

  assign sck_s     = sck_pipe[SYNC_STAGES-1];
  assign sce_s     = sce_pipe[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_dly;
  assign sck_fall  = ~sck_s & sck_dly;
  assign sce_level = sce_s;
  assign sce_rise  = sce_s & ~sce_dly;
  assign sce_fall  = ~sce_s & sce_dly;
  assign sio_sync  = sio_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/xspi_phy_os.sv
// xspi_phy_os: oversampling xSPI slave PHY, fully in the clk domain.
//   clk_i, rst_ni          system clock (>= 4x SCK), async active-low reset
//   sck_i, sce_i, sio_i    raw pins from the pads
//   sio_o, sio_oe          lane data / per-lane output enable to the pads
//   txnstart_i             strobe arming a phase of txnbc_i beats in
//                          txnmode_i width and txndir_i direction
//   txndata_i / txndata_o  right-justified transmit / receive data
//   txndone_o, txnabort_o, txnerr_o  one-clk status pulses
//   busy_o, sel_o          phase active / selected
module xspi_phy_os
  import xspi_pkg::*;
#(
  parameter int DATA_BITS        = 32,
  parameter int CYCLE_COUNT_BITS = 8,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sck_i,
  input  logic                        sce_i,
  input  logic [3:0]                  sio_i,
  output logic [3:0]                  sio_o,
  output logic [3:0]                  sio_oe,
  input  logic                        txnstart_i,
  input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
  input  logic [1:0]                  txnmode_i,
  input  logic                        txndir_i,
  input  logic [DATA_BITS-1:0]        txndata_i,
  output logic [DATA_BITS-1:0]        txndata_o,
  output logic                        txndone_o,
  output logic                        txnabort_o,
  output logic                        txnerr_o,
  output logic                        busy_o,
  output logic                        sel_o
);

  logic       sck_rise, sck_fall, sce_level, sce_rise, sce_fall;
  logic [3:0] sio_s;

  xspi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .sck       (sck_i),
    .sce       (sce_i),
    .sio       (sio_i),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .sce_level (sce_level),
    .sce_rise  (sce_rise),
    .sce_fall  (sce_fall),
    .sio_sync  (sio_s)
  );

  xspi_state_t                 state_reg, state_next;
  logic [CYCLE_COUNT_BITS-1:0] beat_reg, beat_next;
  logic [CYCLE_COUNT_BITS-1:0] bc_reg, bc_next;
  logic [1:0]                  mode_reg, mode_next;
  logic [DATA_BITS-1:0]        rx_reg, rx_next;
  logic [DATA_BITS-1:0]        tx_reg, tx_next;
  logic [3:0]                  oe_reg, oe_next;
  logic                        done_reg, done_next;
  logic                        abort_reg, abort_next;
  logic                        err_reg, err_next;

  // Start qualification, evaluated on the requested mode/count.
  logic [31:0]          req_bits;
  logic [31:0]          tx_shamt;
  logic                 start_ok;
  logic [DATA_BITS-1:0] tx_load;

  assign req_bits = 32'(txnbc_i) * 32'(xspi_bpb(txnmode_i));
  assign start_ok = (txnbc_i != '0) && (txnmode_i != 2'b11) &&
                    (req_bits <= 32'(DATA_BITS));
  // Left-align so the first beat sits in the MSBs of the shifter.
  assign tx_shamt = 32'(DATA_BITS) - req_bits;
  assign tx_load  = txndata_i << tx_shamt;

  // Lane routing for the active phase width.
  logic [2:0]  cur_bpb;
  logic [3:0]  rx_lanes;
  logic [3:0]  tx_drive;
  logic [CYCLE_COUNT_BITS-1:0] beat_inc;

  assign cur_bpb  = xspi_bpb(mode_reg);
  assign beat_inc = beat_reg + 1'b1;

  always_comb begin
    rx_lanes = 4'b0000;
    tx_drive = 4'b0000;
    case (mode_reg)
      XSPI_MODE_SINGLE: begin
        rx_lanes = {3'b000, sio_s[0]};
        tx_drive = {2'b00, tx_reg[DATA_BITS-1], 1'b0};
      end
      XSPI_MODE_DUAL: begin
        rx_lanes = {2'b00, sio_s[1:0]};
        tx_drive = {2'b00, tx_reg[DATA_BITS-1 -: 2]};
      end
      XSPI_MODE_QUAD: begin
        rx_lanes = sio_s;
        tx_drive = tx_reg[DATA_BITS-1 -: 4];
      end
      default: begin
        rx_lanes = 4'b0000;
        tx_drive = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= DESEL;
      beat_reg  <= '0;
      bc_reg    <= '0;
      mode_reg  <= XSPI_MODE_SINGLE;
      rx_reg    <= '0;
      tx_reg    <= '0;
      oe_reg    <= '0;
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      bc_reg    <= bc_next;
      mode_reg  <= mode_next;
      rx_reg    <= rx_next;
      tx_reg    <= tx_next;
      oe_reg    <= oe_next;
      done_reg  <= done_next;
      abort_reg <= abort_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    bc_next    = bc_reg;
    mode_next  = mode_reg;
    rx_next    = rx_reg;
    tx_next    = tx_reg;
    oe_next    = oe_reg;
    done_next  = 1'b0;
    abort_next = 1'b0;
    err_next   = 1'b0;

    if (sce_fall) begin
      // Deselect overrides everything, including a coincident start.
      state_next = DESEL;
      oe_next    = 4'b0000;
      if (state_reg == RX || state_reg == TX) abort_next = 1'b1;
      if (txnstart_i) err_next = 1'b1;
    end else begin
      case (state_reg)
        DESEL: if (sce_rise) state_next = SEL;
        RX: begin
          if (sck_rise) begin
            rx_next   = (rx_reg << cur_bpb) | DATA_BITS'(rx_lanes);
            beat_next = beat_inc;
            if (beat_inc == bc_reg) begin
              done_next  = 1'b1;
              state_next = SEL;
            end
          end
        end
        TX: begin
          if (sck_rise) begin
            beat_next = beat_inc;
          end else if (sck_fall && beat_reg != '0) begin
            // A zero beat count means no rise yet: a leading fall
            // (SCK idling high) must not advance the shifter.
            if (beat_reg == bc_reg) begin
              done_next  = 1'b1;
              state_next = SEL;
            end else begin
              tx_next = tx_reg << cur_bpb;
            end
          end
        end
        default: ;
      endcase

      if (txnstart_i) begin
        if (state_reg != SEL || !start_ok) begin
          err_next = 1'b1;
        end else begin
          beat_next = '0;
          bc_next   = txnbc_i;
          mode_next = txnmode_i;
          if (txndir_i) begin
            state_next = TX;
            tx_next    = tx_load;
            oe_next    = xspi_tx_lanes(txnmode_i);
          end else begin
            state_next = RX;
            rx_next    = '0;
            tx_next    = '0;
            oe_next    = 4'b0000;
          end
        end
      end
    end
  end

  assign sio_o      = tx_drive & oe_reg;
  assign sio_oe     = oe_reg;
  assign txndata_o  = rx_reg;
  assign txndone_o  = done_reg;
  assign txnabort_o = abort_reg;
  assign txnerr_o   = err_reg;
  assign busy_o     = (state_reg == RX) || (state_reg == TX);
  assign sel_o      = sce_level && (state_reg != DESEL);

endmodule

// File: tb/tb_xspi_phy_os.sv
// tb_xspi_phy_os: directed plus randomized bench for xspi_phy_os.
// clk 100 MHz, SCK 12.5 MHz; a host model drives SCK/SCE/SIO and samples
// the PHY's lanes on SCK rises. Expected values come from plain arithmetic
// on the transferred words.
module tb_xspi_phy_os;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        sce = 1'b0;
  logic [3:0]  sio_in = 4'h0;
  logic [3:0]  sio_out;
  logic [3:0]  sio_oe;
  logic        txnstart = 1'b0;
  logic [7:0]  txnbc = 8'd0;
  logic [1:0]  txnmode = 2'b00;
  logic        txndir = 1'b0;
  logic [31:0] txndata_in = 32'h0;
  logic [31:0] txndata_out;
  logic        txndone, txnabort, txnerr, busy, sel;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, abort_cnt = 0, err_cnt = 0, oe_cycles = 0;

  xspi_phy_os dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sck_i      (sck),
    .sce_i      (sce),
    .sio_i      (sio_in),
    .sio_o      (sio_out),
    .sio_oe     (sio_oe),
    .txnstart_i (txnstart),
    .txnbc_i    (txnbc),
    .txnmode_i  (txnmode),
    .txndir_i   (txndir),
    .txndata_i  (txndata_in),
    .txndata_o  (txndata_out),
    .txndone_o  (txndone),
    .txnabort_o (txnabort),
    .txnerr_o   (txnerr),
    .busy_o     (busy),
    .sel_o      (sel)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (txndone)     done_cnt++;
    if (txnabort)    abort_cnt++;
    if (txnerr)      err_cnt++;
    if (sio_oe != 0) oe_cycles++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic hclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bpb_of(input logic [1:0] m);
    if (m == 2'b00) return 1;
    if (m == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] txmask_of(input logic [1:0] m);
    if (m == 2'b00) return 4'b0010;
    if (m == 2'b01) return 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] low_mask(input int bits);
    logic [63:0] w;
    w = (64'd1 << bits) - 64'd1;
    return w[31:0];
  endfunction

  task automatic start(input logic [1:0] m, input int bc, input logic d, input logic [31:0] data);
    @(negedge clk);
    txnstart   = 1'b1;
    txnmode    = m;
    txnbc      = 8'(bc);
    txndir     = d;
    txndata_in = data;
    @(negedge clk);
    txnstart   = 1'b0;
  endtask

  // Mode-0 host: data set while SCK low, SCK rises (host samples), falls.
  // RX beat i carries the bpb-bit group of rx_word at position bc-1-i.
  task automatic run_phase(input logic [1:0] m, input int bc, input logic d,
                           input logic [31:0] rx_word, input int beats,
                           output logic [31:0] tx_seen, output logic lanes_ok);
    int b;
    logic [31:0] v;
    logic [3:0] r;
    b = bpb_of(m);
    tx_seen = 32'h0;
    lanes_ok = 1'b1;
    for (int i = 0; i < beats; i++) begin
      v = (rx_word >> ((bc - 1 - i) * b)) & low_mask(b);
      r = 4'($urandom);
      if (b == 1)      sio_in = {r[3:1], v[0]};
      else if (b == 2) sio_in = {r[3:2], v[1:0]};
      else             sio_in = v[3:0];
      hclk(4);
      sck = 1'b1;
      if (d) begin
        if (b == 1)      tx_seen = (tx_seen << 1) | 32'(sio_out[1]);
        else if (b == 2) tx_seen = (tx_seen << 2) | 32'(sio_out[1:0]);
        else             tx_seen = (tx_seen << 4) | 32'(sio_out);
        if (sio_oe !== txmask_of(m) || (sio_out & ~txmask_of(m)) != 4'h0) lanes_ok = 1'b0;
      end else begin
        if (sio_oe !== 4'h0) lanes_ok = 1'b0;
      end
      hclk(4);
      sck = 1'b0;
    end
    hclk(6);
  endtask

  initial begin
    logic [31:0] seen, data, exp;
    logic ok;
    logic [1:0] m;
    logic d;
    int bc, d0, a0, e0, o0;

    // Reset state
    hclk(3);
    chk("reset_outputs", {13'h0, sio_out, sio_oe, txndone, txnabort, txnerr, busy, sel, 5'h0},
        32'h0);
    chk("reset_rxdata", txndata_out, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    hclk(4);
    chk("desel_sel", 32'(sel), 32'h0);

    sce = 1'b1;
    hclk(5);
    chk("select_sel", 32'(sel), 32'h1);

    // Quad RX 0xDEADBEEF
    d0 = done_cnt; o0 = oe_cycles;
    start(2'b10, 8, 1'b0, 32'h0);
    run_phase(2'b10, 8, 1'b0, 32'hDEADBEEF, 8, seen, ok);
    chk("quad_rx_data", txndata_out, 32'hDEADBEEF);
    chk("quad_rx_done", 32'(done_cnt - d0), 32'd1);
    chk("quad_rx_oe", 32'(oe_cycles - o0), 32'd0);
    $display("txn quad_rx: data=0x%08h", txndata_out);

    // Single TX 0xA5
    d0 = done_cnt;
    start(2'b00, 8, 1'b1, 32'hA5);
    run_phase(2'b00, 8, 1'b1, 32'h0, 8, seen, ok);
    chk("single_tx_bits", seen, 32'hA5);
    chk("single_tx_lanes", 32'(ok), 32'h1);
    chk("single_tx_done", 32'(done_cnt - d0), 32'd1);
    chk("single_tx_oe_hold", 32'(sio_oe), 32'h2);
    $display("txn single_tx: seen=0x%02h", seen[7:0]);

    // Dual RX 00,11,11,00
    start(2'b01, 4, 1'b0, 32'h0);
    run_phase(2'b01, 4, 1'b0, 32'h3C, 4, seen, ok);
    chk("dual_rx_data", txndata_out, 32'h0000003C);
    chk("dual_rx_turnaround", 32'(ok), 32'h1);
    $display("txn dual_rx: data=0x%08h", txndata_out);

    // Quad RX aborted after 3 beats
    d0 = done_cnt; a0 = abort_cnt; e0 = err_cnt;
    start(2'b10, 8, 1'b0, 32'h0);
    run_phase(2'b10, 8, 1'b0, 32'h12345678, 3, seen, ok);
    sce = 1'b0;
    hclk(6);
    chk("abort_pulse", 32'(abort_cnt - a0), 32'd1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_state", {28'h0, sel, busy, 2'b00}, 32'h0);
    chk("abort_oe", 32'(sio_oe), 32'h0);
    start(2'b10, 4, 1'b0, 32'h0);
    hclk(3);
    chk("desel_start_err", 32'(err_cnt - e0), 32'd1);
    $display("txn abort: aborts=%0d", abort_cnt - a0);

    // Rejected starts, then a valid one
    sce = 1'b1;
    hclk(5);
    e0 = err_cnt;
    start(2'b10, 9, 1'b0, 32'h0);
    hclk(2);
    chk("err_quad9", 32'(err_cnt - e0), 32'd1);
    chk("err_quad9_busy", 32'(busy), 32'h0);
    start(2'b00, 0, 1'b0, 32'h0);
    hclk(2);
    chk("err_bc0", 32'(err_cnt - e0), 32'd2);
    start(2'b11, 4, 1'b1, 32'h0);
    hclk(2);
    chk("err_mode3", 32'(err_cnt - e0), 32'd3);
    chk("err_busy", 32'(busy), 32'h0);
    start(2'b10, 2, 1'b0, 32'h0);
    hclk(1);
    chk("valid_busy", 32'(busy), 32'h1);
    run_phase(2'b10, 2, 1'b0, 32'h9A, 2, seen, ok);
    chk("valid_data", txndata_out, 32'h9A);
    $display("txn errors: rejected=%0d", err_cnt - e0);

    // Randomized phases against the arithmetic model
    for (int t = 0; t < 8; t++) begin
      m    = 2'($urandom_range(0, 2));
      d    = 1'($urandom_range(0, 1));
      bc   = $urandom_range(1, 32 / bpb_of(m));
      data = $urandom;
      exp  = data & low_mask(bc * bpb_of(m));
      d0   = done_cnt;
      start(m, bc, d, d ? data : 32'h0);
      run_phase(m, bc, d, data, bc, seen, ok);
      chk(d ? "rand_tx_bits" : "rand_rx_data", d ? seen : txndata_out, exp);
      chk("rand_lanes", 32'(ok), 32'h1);
      chk("rand_done", 32'(done_cnt - d0), 32'd1);
      $display("txn %0d: mode=%0d dir=%0d bc=%0d expect=0x%08h got=0x%08h",
               t, m, d, bc, exp, d ? seen : txndata_out);
    end

    // Reset mid-TX
    start(2'b00, 8, 1'b1, 32'hFF);
    run_phase(2'b00, 8, 1'b1, 32'h0, 3, seen, ok);
    d0 = done_cnt; a0 = abort_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {13'h0, sio_out, sio_oe, txndone, txnabort, txnerr, busy, sel, 5'h0},
        32'h0);
    chk("midreset_rxdata", txndata_out, 32'h0);
    sce = 1'b0;
    sck = 1'b1;
    hclk(3);
    chk("midreset_no_pulses", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    hclk(5);
    sce = 1'b1;
    hclk(5);
    chk("mode3_select", 32'(sel), 32'h1);

    // Mode-3 single TX 0x5: SCK idles high, leading fall ignored
    d0 = done_cnt;
    start(2'b00, 4, 1'b1, 32'h5);
    seen = 32'h0;
    for (int i = 0; i < 4; i++) begin
      hclk(4);
      sck = 1'b0;
      hclk(4);
      sck = 1'b1;
      seen = (seen << 1) | 32'(sio_out[1]);
    end
    hclk(4);
    sck = 1'b0;
    hclk(6);
    sck = 1'b1;
    chk("mode3_tx_bits", seen, 32'h5);
    chk("mode3_tx_done", 32'(done_cnt - d0), 32'd1);
    $display("txn mode3_tx: seen=0x%01h", seen[3:0]);
    hclk(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
